dm_responder: RTL and testbench

Data-memory responder for the MIPS core. It serves load/store requests over a valid/ready request channel and a one-cycle response pulse, with a configurable number of wait states. It sits between the CPU datapath (the initiator) and a word-organised RAM, and replaces the zero-latency combinational data memory once the core moves to handshaked memory access. Each committed store produces a simulation log line tagged with the requesting PC.

---
 rtl/dm_pkg.sv | 33 +++
 rtl/dm_array.sv | 60 ++++++
 rtl/dm_responder.sv | 167 ++++++++++++++++
 tb/tb_dm_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder.
//   dm_state_e : responder FSM states (IDLE, WAIT, RESP)
//   DM_LOG_FMT : format of the committed-store trace line (pc, word address, merged word)
//   be_merge   : byte-enable merge of store data into an existing word
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    localparam string DM_LOG_FMT = "@%h: *%h <= %h";

    // Replace each byte of old_word whose enable bit is set by the matching byte of wdata.
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Word-organised data storage behind the responder.
// One synchronous access port: a store merges enabled bytes into the addressed
// word, a load registers the addressed word. Reset clears every word.
//   clk, reset : clock, synchronous active-high reset
//   i_en       : perform an access this edge
//   i_we       : 1 = store (byte-enable merge), 0 = read
//   i_zero     : for reads, register 0 instead of the word (rejected request)
//   i_be       : byte enables for stores
//   i_addr     : word index
//   i_wdata    : store data
//   o_rdata    : registered read data (0 after stores and rejected reads)
//   o_wword    : registered merged word of the most recent store
module dm_array
    import dm_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_we,
    input  logic              i_zero,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic [31:0]       o_wword
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic [31:0] r_wword;
    logic [31:0] w_merged;

    assign w_merged = be_merge(r_mem[i_addr], i_wdata, i_be);
    assign o_rdata  = r_rdata;
    assign o_wword  = r_wword;

    // Storage port: clear on reset, otherwise merge-write or registered read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
            r_rdata <= 32'd0;
            r_wword <= 32'd0;
        end else if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= w_merged;
                r_wword       <= w_merged;
                r_rdata       <= 32'd0;
            end else begin
                r_rdata <= i_zero ? 32'd0 : r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Handshaked data-memory responder for the MIPS core.
// Accepts one load/store on a valid/ready channel, waits LATENCY cycles, then
// commits it to dm_array and raises a one-cycle response pulse.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_we, req_be      : store flag and byte enables
//   req_addr, req_wdata : byte address and store data
//   req_pc              : issuing PC, used by the store trace only
//   resp_valid          : one-cycle response pulse
//   resp_rdata          : load data (0 for stores and errors), held between pulses
//   resp_err            : misaligned or out-of-range request, held between pulses
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    // With no wait states the commit happens on the accepting edge, so the
    // request is taken straight from the inputs instead of the capture registers.
    localparam bit DIRECT = (LATENCY == 0);

    dm_state_e   r_state;
    dm_state_e   w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic        r_log_en;
    logic [31:0] r_log_pc;
    logic [31:0] r_log_addr;

    logic        w_accept;
    logic        w_commit;
    logic        w_c_we;
    logic [3:0]  w_c_be;
    logic [31:0] w_c_addr;
    logic [31:0] w_c_wdata;
    logic [31:0] w_c_pc;
    logic        w_err;
    logic [31:0] w_arr_rdata;
    logic [31:0] w_wword;

    assign req_ready = !reset && (r_state != WAIT);
    assign w_accept  = req_valid && req_ready;

    assign w_c_we    = DIRECT ? req_we    : r_we;
    assign w_c_be    = DIRECT ? req_be    : r_be;
    assign w_c_addr  = DIRECT ? req_addr  : r_addr;
    assign w_c_wdata = DIRECT ? req_wdata : r_wdata;
    assign w_c_pc    = DIRECT ? req_pc    : r_pc;

    // Anything above the mapped word range or not word-aligned is rejected.
    assign w_err = (w_c_addr[1:0] != 2'b00) || ((w_c_addr >> (ADDR_W + 2)) != 32'd0);

    // The request executes on the edge that enters RESP.
    assign w_commit = (w_next == RESP) && !reset;

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = w_arr_rdata;

    // Next-state selection.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    w_next = (LATENCY > 0) ? WAIT : RESP;
                end else begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end else begin
                    w_next = WAIT;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, wait counter, request capture and response flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_be         <= 4'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_pc         <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_log_en     <= 1'b0;
            r_log_pc     <= 32'd0;
            r_log_addr   <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_be    <= req_be;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_pc    <= req_pc;
                r_cnt   <= LAT_M1;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_resp_valid <= w_commit;
            if (w_commit) begin
                r_resp_err <= w_err;
                r_log_pc   <= w_c_pc;
                r_log_addr <= {w_c_addr[31:2], 2'b00};
            end
            // A store with no enabled bytes leaves memory untouched and is not traced.
            r_log_en <= w_commit && w_c_we && !w_err && (w_c_be != 4'd0);
        end
    end

    dm_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_commit),
        .i_we    (w_c_we && !w_err),
        .i_zero  (w_err),
        .i_be    (w_c_be),
        .i_addr  (w_c_addr[ADDR_W+1:2]),
        .i_wdata (w_c_wdata),
        .o_rdata (w_arr_rdata),
        .o_wword (w_wword)
    );

`ifndef SYNTHESIS
    // Store trace, emitted once the merged word of the committed store is registered.
    always_ff @(posedge clk) begin
        if (r_log_en) begin
            $display(DM_LOG_FMT, r_log_pc, r_log_addr, w_wword);
        end
    end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: one instance with LATENCY=2 and one with LATENCY=0,
// exercised in turn with directed and random requests against a transaction
// model (word map, response queue with due cycles, busy window).
module tb_dm_responder;

    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst = 2'b00;
    logic [1:0]       rv  = 2'b00;
    logic [1:0]       rwe = 2'b00;
    logic [1:0][3:0]  rbe = '0;
    logic [1:0][31:0] raddr = '0;
    logic [1:0][31:0] rwd = '0;
    logic [1:0][31:0] rpc = '0;
    logic [1:0]       rrdy;
    logic [1:0]       svld;
    logic [1:0]       serr;
    logic [1:0][31:0] srd;

    dm_responder #(.ADDR_W(AW), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rrdy[0]),
        .req_we(rwe[0]), .req_be(rbe[0]), .req_addr(raddr[0]), .req_wdata(rwd[0]),
        .req_pc(rpc[0]), .resp_valid(svld[0]), .resp_rdata(srd[0]), .resp_err(serr[0])
    );

    dm_responder #(.ADDR_W(AW), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rrdy[1]),
        .req_we(rwe[1]), .req_be(rbe[1]), .req_addr(raddr[1]), .req_wdata(rwd[1]),
        .req_pc(rpc[1]), .resp_valid(svld[1]), .resp_rdata(srd[1]), .resp_err(serr[1])
    );

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       q[$];
    logic [31:0] mem[int];
    int          t = 0;
    int          busy_until = -100;
    int          lat = 2;
    bit          started = 1'b0;
    bit          acc = 1'b0;
    logic [31:0] held_rd = 32'd0;
    logic        held_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [31:0] rd_mem(input int idx);
        return mem.exists(idx) ? mem[idx] : 32'd0;
    endfunction

    task automatic begin_phase(input int k);
        q.delete();
        mem.delete();
        busy_until = -100;
        started    = 1'b0;
        lat        = (k == 0) ? 2 : 0;
        held_rd    = 32'd0;
        held_err   = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, update the model.
    task automatic step(input int k, input logic v, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd, input logic r);
        resp_t       e;
        logic        exp_rdy;
        logic        bad_addr;
        logic [31:0] w;
        int          idx;
        @(negedge clk);
        t++;
        rst[k]   = r;
        rv[k]    = v;
        rwe[k]   = we;
        rbe[k]   = be;
        raddr[k] = addr;
        rwd[k]   = wd;
        rpc[k]   = 32'h0040_0000 + 32'(t * 4);
        #1;
        exp_rdy = !r && (t > busy_until);
        chk("req_ready", {31'd0, rrdy[k]}, {31'd0, exp_rdy});
        if (started) begin
            if ((q.size() > 0) && (q[0].due == t)) begin
                e = q.pop_front();
                held_rd  = e.rdata;
                held_err = e.err;
                chk("resp_valid", {31'd0, svld[k]}, 32'd1);
            end else begin
                chk("resp_valid", {31'd0, svld[k]}, 32'd0);
            end
            chk("resp_rdata", srd[k], held_rd);
            chk("resp_err", {31'd0, serr[k]}, {31'd0, held_err});
        end
        acc = 1'b0;
        if (r) begin
            q.delete();
            mem.delete();
            busy_until = t;
            held_rd    = 32'd0;
            held_err   = 1'b0;
            started    = 1'b1;
        end else if (v && exp_rdy) begin
            acc      = 1'b1;
            bad_addr = (addr[1:0] != 2'b00) || (addr >= (32'd1 << (AW + 2)));
            idx      = int'(addr >> 2);
            e.due    = t + 1 + lat;
            e.err    = bad_addr;
            e.rdata  = 32'd0;
            if (!bad_addr) begin
                if (!we) begin
                    e.rdata = rd_mem(idx);
                end else begin
                    w = rd_mem(idx);
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                    end
                    mem[idx] = w;
                end
            end
            q.push_back(e);
            busy_until = t + lat;
        end
    endtask

    task automatic idle(input int k);
        step(k, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    // Hold a request until the model says it is accepted (bounded).
    task automatic req(input int k, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        do begin
            step(k, 1'b1, we, be, addr, wd, 1'b0);
            n++;
        end while (!acc && (n < 20));
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input int k);
        for (int i = 0; i < lat + 1; i++) idle(k);
    endtask

    task automatic expect_load(input int k, input string tag, input logic [31:0] addr,
                               input logic [31:0] exp);
        req(k, 1'b0, 4'd0, addr, 32'd0);
        wait_resp(k);
        chk(tag, srd[k], exp);
    endtask

    task automatic random_run(input int k, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 15))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(1, 3));
                2:       a = 32'h0000_3FFC;
                default: a = 32'($urandom_range(0, 15) * 4);
            endcase
            step(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 a, $urandom, 1'($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 8; i++) idle(k);
    endtask

    initial begin
        // LATENCY = 2 instance
        begin_phase(0);
        step(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        step(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        expect_load(0, "load_after_reset", 32'h10, 32'd0);
        req(0, 1'b1, 4'b1111, 32'h20, 32'h1122_3344);
        req(0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        expect_load(0, "be_merge", 32'h20, 32'h11BB_33DD);
        expect_load(0, "misaligned_rdata", 32'h22, 32'd0);
        chk("misaligned_err", {31'd0, serr[0]}, 32'd1);
        req(0, 1'b1, 4'b1111, 32'h0, 32'h1234_5678);
        req(0, 1'b1, 4'b1111, 32'h4000, 32'hFFFF_FFFF);
        wait_resp(0);
        chk("range_err", {31'd0, serr[0]}, 32'd1);
        expect_load(0, "range_no_alias", 32'h0, 32'h1234_5678);
        req(0, 1'b1, 4'b1111, 32'h40, 32'hDEAD_BEEF);
        step(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        idle(0);
        idle(0);
        idle(0);
        expect_load(0, "reset_drops_store", 32'h40, 32'd0);
        req(0, 1'b1, 4'b1111, 32'h8, 32'h0000_0005);
        req(0, 1'b1, 4'b0000, 32'h8, 32'hFFFF_FFFF);
        wait_resp(0);
        chk("be0_no_err", {31'd0, serr[0]}, 32'd0);
        expect_load(0, "be0_no_write", 32'h8, 32'h0000_0005);
        random_run(0, 300);

        // LATENCY = 0 instance
        begin_phase(1);
        step(1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        step(1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        req(1, 1'b1, 4'b1111, 32'h4, 32'hA0A0_0004);
        req(1, 1'b1, 4'b1111, 32'h8, 32'hB0B0_0008);
        req(1, 1'b1, 4'b1111, 32'hC, 32'hC0C0_000C);
        req(1, 1'b0, 4'd0, 32'h4, 32'd0);
        req(1, 1'b0, 4'd0, 32'h8, 32'd0);
        req(1, 1'b0, 4'd0, 32'hC, 32'd0);
        idle(1);
        chk("stream_last_load", srd[1], 32'hC0C0_000C);
        expect_load(1, "stream_first_load", 32'h4, 32'hA0A0_0004);
        random_run(1, 300);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
